psr_cond_unit: RTL and testbench
================================

PSR_COND_UNIT -- requirements
Module: psr_cond_unit

Interface
REQ-001 SHALL have parameter PSR_W, default 16, processor status register width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have inputs carry, low, flag, zero, negative  input  1 each  ALU flag outputs, same cycle as ALU result.
REQ-005 SHALL have input flag_we  input  1  commit ALU flags this cycle.
REQ-006 SHALL have input flag_mask  input  5  per-flag update enable, order {C,L,F,Z,N}.
REQ-007 SHALL have input psr_we  input  1  and psr_wdata  input  16  full PSR load (LPR).
REQ-008 SHALL have inputs irq_enter, irq_return  input  1 each  interrupt entry/return strobes.
REQ-009 SHALL have inputs cond_valid  input  1  and cond  input  4  condition evaluation request.
REQ-010 SHALL have outputs take  output  1  and take_valid  output  1  registered condition result.
REQ-011 SHALL have outputs psr  output  16  current PSR, and in_irq  output  1  interrupt state.

Function
REQ-012 PSR bit map SHALL be C=0, L=2, F=5, Z=6, N=7, E=9; all other bits read 0 and ignore writes.
REQ-013 On flag_we, only flags with flag_mask bit set SHALL update; unmasked flags hold.
REQ-014 Condition codes SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 10 LO !L&!Z; 11 HS L|Z; 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 never 0.
REQ-015 take/take_valid SHALL be registered, valid exactly one cycle after cond_valid, take_valid low otherwise.
REQ-016 Evaluation SHALL forward: when flag_we and cond_valid coincide, cond SHALL use post-update flags.
REQ-017 FSM SHALL have states NORMAL and IRQ; in_irq=1 in IRQ.
REQ-018 NORMAL + irq_enter: shadow <= PSR value after same-cycle flag/psr update, PSR.E <= 0, go IRQ.
REQ-019 IRQ + irq_return: PSR <= shadow, go NORMAL; same-cycle flag_we and psr_we discarded.
REQ-020 irq_enter in IRQ and irq_return in NORMAL SHALL be ignored (no nesting).
REQ-021 Same-cycle priority SHALL be reset > irq_return > psr_we > flag_we; psr_we overrides flag_we for all bits.
REQ-022 psr output SHALL reflect registered state only (no combinational path from inputs).

Reset
REQ-023 reset SHALL set psr=0, shadow=0, take=0, take_valid=0, state NORMAL, in_irq=0.
REQ-024 reset mid-interrupt SHALL discard shadow; a request pending with reset SHALL yield no take_valid.

Structure
REQ-025 Shared package psr_pkg SHALL hold PSR bit positions, 4-bit condition code constants and ALU control codes (AND 0, OR 1, XOR 2, ADD 3, SUB 4, LSHIFT 5, RSHIFT 6).
REQ-026 Condition decode SHALL be a combinational sub-module cond_eval (flags, cond -> take).
REQ-027 FSM state encoding SHALL be a package typedef.

Verification
REQ-028 After reset, flag_we mask 5'b11111 with carry=1, others 0 -> next cycle psr=16'h0001; cond CS -> take=1, CC -> take=0.
REQ-029 Same cycle flag_we (zero=1, mask Z only) and cond_valid EQ -> take=1 one cycle later (forwarding).
REQ-030 psr_we 16'hFFFF -> psr=16'h02E5; then irq_enter -> psr=16'h00E5, in_irq=1; flag_we mask all zeros-in -> psr=16'h0000; irq_return -> psr=16'h02E5, in_irq=0.
REQ-031 psr_we 16'h0040 and flag_we (zero=0) same cycle -> psr=16'h0040; second irq_enter while in_irq ignored.
REQ-032 Sweep all 16 conds over all 32 flag combinations -> take matches REQ-014 table, cond 15 always 0, cond 14 always 1.
REQ-033 Assert reset during IRQ with cond_valid high -> next cycle psr=0, in_irq=0, take_valid=0.

Source files
------------

// File: rtl/psr_pkg.sv
// psr_pkg: shared PSR bit map, condition codes, ALU control codes and FSM state type
package psr_pkg;
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;
  localparam int PSR_E = 9;
  localparam logic [15:0] PSR_WMASK = 16'h02E5;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  typedef enum logic [2:0] {
    ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_XOR = 3'd2, ALU_ADD = 3'd3,
    ALU_SUB = 3'd4, ALU_LSHIFT = 3'd5, ALU_RSHIFT = 3'd6
  } alu_op_t;
  typedef enum logic {ST_NORMAL = 1'b0, ST_IRQ = 1'b1} irq_state_t;
  typedef struct packed {
    logic c;
    logic l;
    logic f;
    logic z;
    logic n;
  } flags_t;
endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// cond_eval: combinational condition-code decode of the five ALU flags
module cond_eval
  import psr_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond,
  output logic       take
);
  logic [15:0] tbl;
  assign tbl = {1'b0, 1'b1,
                flags.n | flags.z, ~flags.n & ~flags.z,
                flags.l | flags.z, ~flags.l & ~flags.z,
                ~flags.f, flags.f, ~flags.n, flags.n,
                ~flags.l, flags.l, ~flags.c, flags.c,
                ~flags.z, flags.z};
  assign take = tbl[cond];
endmodule

// File: rtl/psr_cond_unit.sv
// psr_cond_unit: processor status register with masked flag commit, single-level
// interrupt shadowing and a registered condition-code evaluator
module psr_cond_unit
  import psr_pkg::*;
#(
  parameter int PSR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carry,
  input  logic             low,
  input  logic             flag,
  input  logic             zero,
  input  logic             negative,
  input  logic             flag_we,
  input  logic [4:0]       flag_mask,
  input  logic             psr_we,
  input  logic [PSR_W-1:0] psr_wdata,
  input  logic             irq_enter,
  input  logic             irq_return,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic             take,
  output logic             take_valid,
  output logic [PSR_W-1:0] psr,
  output logic             in_irq
);
  localparam logic [PSR_W-1:0] WMASK = PSR_W'(PSR_WMASK);
  localparam logic [PSR_W-1:0] E_BIT = PSR_W'(1) << PSR_E;
  irq_state_t state, state_nx;
  logic [PSR_W-1:0] shadow, shadow_nx, flag_upd, psr_upd, psr_nx;
  logic ent, ret, take_nx;
  flags_t fl;
  always_comb begin
    flag_upd = psr;
    flag_upd[PSR_C] = flag_we && flag_mask[4] ? carry : psr[PSR_C];
    flag_upd[PSR_L] = flag_we && flag_mask[3] ? low : psr[PSR_L];
    flag_upd[PSR_F] = flag_we && flag_mask[2] ? flag : psr[PSR_F];
    flag_upd[PSR_Z] = flag_we && flag_mask[1] ? zero : psr[PSR_Z];
    flag_upd[PSR_N] = flag_we && flag_mask[0] ? negative : psr[PSR_N];
    psr_upd = psr_we ? psr_wdata & WMASK : flag_upd;
    ent = state == ST_NORMAL && irq_enter;
    ret = state == ST_IRQ && irq_return;
    psr_nx = ret ? shadow : ent ? psr_upd & ~E_BIT : psr_upd;
    shadow_nx = ent ? psr_upd : shadow;
    state_nx = ret ? ST_NORMAL : ent ? ST_IRQ : state;
  end
  // conditions see the flags as they will be after this edge
  assign fl = {psr_nx[PSR_C], psr_nx[PSR_L], psr_nx[PSR_F], psr_nx[PSR_Z], psr_nx[PSR_N]};
  cond_eval u_eval (.flags(fl), .cond(cond), .take(take_nx));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_NORMAL;
      psr <= '0;
      shadow <= '0;
      take <= 1'b0;
      take_valid <= 1'b0;
    end else begin
      state <= state_nx;
      psr <= psr_nx;
      shadow <= shadow_nx;
      take <= cond_valid && take_nx;
      take_valid <= cond_valid;
    end
  end
  assign in_irq = state == ST_IRQ;
endmodule

// File: tb/tb_psr_cond_unit.sv
// tb_psr_cond_unit: directed and randomized checks of psr_cond_unit against a behavioural model
module tb_psr_cond_unit;
  logic clk = 0, reset = 1;
  logic carry = 0, low = 0, flag = 0, zero = 0, negative = 0;
  logic flag_we = 0, psr_we = 0, irq_enter = 0, irq_return = 0, cond_valid = 0;
  logic [4:0] flag_mask = 0;
  logic [15:0] psr_wdata = 0;
  logic [3:0] cond = 0;
  logic take, take_valid, in_irq;
  logic [15:0] psr;
  int total = 0, bad = 0;
  logic [15:0] m_psr = 0, m_sh = 0;
  logic m_irq = 0, e_tv = 0, e_take = 0;

  psr_cond_unit #(.PSR_W(16)) dut (
    .clk(clk), .reset(reset), .carry(carry), .low(low), .flag(flag), .zero(zero),
    .negative(negative), .flag_we(flag_we), .flag_mask(flag_mask), .psr_we(psr_we),
    .psr_wdata(psr_wdata), .irq_enter(irq_enter), .irq_return(irq_return),
    .cond_valid(cond_valid), .cond(cond), .take(take), .take_valid(take_valid),
    .psr(psr), .in_irq(in_irq)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ref(input logic [3:0] cc, input logic c, l, f, z, n);
    case (cc)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return l;
      5: return !l;
      6: return n;
      7: return !n;
      8: return f;
      9: return !f;
      10: return !l && !z;
      11: return l || z;
      12: return !n && !z;
      13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clock();
    logic [15:0] p;
    if (reset) begin
      m_psr = 0; m_sh = 0; m_irq = 0; e_tv = 0; e_take = 0;
    end else begin
      p = m_psr;
      if (m_irq && irq_return) begin
        p = m_sh;
        m_irq = 0;
      end else begin
        if (psr_we) p = psr_wdata & 16'h02E5;
        else if (flag_we) begin
          if (flag_mask[4]) p[0] = carry;
          if (flag_mask[3]) p[2] = low;
          if (flag_mask[2]) p[5] = flag;
          if (flag_mask[1]) p[6] = zero;
          if (flag_mask[0]) p[7] = negative;
        end
        if (!m_irq && irq_enter) begin
          m_sh = p;
          p[9] = 0;
          m_irq = 1;
        end
      end
      e_tv = cond_valid;
      e_take = cond_valid && cond_ref(cond, p[0], p[2], p[5], p[6], p[7]);
      m_psr = p;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flag_we = 0; psr_we = 0; irq_enter = 0; irq_return = 0; cond_valid = 0;
    flag_mask = 0; carry = 0; low = 0; flag = 0; zero = 0; negative = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    total++;
    if (psr !== 16'h0 || in_irq !== 1'b0 || take_valid !== 1'b0 || take !== 1'b0) begin
      bad++; $display("FAIL reset: psr=%h in_irq=%b tv=%b take=%b want 0000/0/0/0", psr, in_irq, take_valid, take);
    end
    idle();
  endtask

  task automatic test_flags();
    flag_we = 1; flag_mask = 5'b11111; carry = 1; tick(); idle();
    total++;
    if (psr !== 16'h0001) begin bad++; $display("FAIL flag_commit: psr=%h want 0001", psr); end
    cond_valid = 1; cond = 4'd2; tick();
    total++;
    if (take_valid !== 1'b1 || take !== 1'b1) begin bad++; $display("FAIL cond_cs: tv=%b take=%b want 1/1", take_valid, take); end
    cond = 4'd3; tick(); idle();
    total++;
    if (take_valid !== 1'b1 || take !== 1'b0) begin bad++; $display("FAIL cond_cc: tv=%b take=%b want 1/0", take_valid, take); end
    tick();
    total++;
    if (take_valid !== 1'b0) begin bad++; $display("FAIL tv_idle: tv=%b want 0", take_valid); end
  endtask

  task automatic test_forward();
    flag_we = 1; flag_mask = 5'b00010; zero = 1; cond_valid = 1; cond = 4'd0; tick(); idle();
    total++;
    if (take_valid !== 1'b1 || take !== 1'b1 || psr !== 16'h0041) begin
      bad++; $display("FAIL forward_eq: tv=%b take=%b psr=%h want 1/1/0041", take_valid, take, psr);
    end
  endtask

  task automatic test_irq();
    psr_we = 1; psr_wdata = 16'hFFFF; tick(); idle();
    total++;
    if (psr !== 16'h02E5) begin bad++; $display("FAIL psr_load: psr=%h want 02E5", psr); end
    irq_enter = 1; tick(); idle();
    total++;
    if (psr !== 16'h00E5 || in_irq !== 1'b1) begin bad++; $display("FAIL irq_enter: psr=%h in_irq=%b want 00E5/1", psr, in_irq); end
    flag_we = 1; flag_mask = 5'b11111; tick(); idle();
    total++;
    if (psr !== 16'h0000) begin bad++; $display("FAIL irq_flags: psr=%h want 0000", psr); end
    irq_return = 1; tick(); idle();
    total++;
    if (psr !== 16'h02E5 || in_irq !== 1'b0) begin bad++; $display("FAIL irq_return: psr=%h in_irq=%b want 02E5/0", psr, in_irq); end
  endtask

  task automatic test_priority();
    psr_we = 1; psr_wdata = 16'h0040; flag_we = 1; flag_mask = 5'b11111; zero = 0; carry = 1; tick(); idle();
    total++;
    if (psr !== 16'h0040) begin bad++; $display("FAIL psr_over_flag: psr=%h want 0040", psr); end
    irq_return = 1; tick(); idle();
    total++;
    if (psr !== 16'h0040 || in_irq !== 1'b0) begin bad++; $display("FAIL return_in_normal: psr=%h in_irq=%b want 0040/0", psr, in_irq); end
    irq_enter = 1; tick(); idle();
    psr_we = 1; psr_wdata = 16'hFFFF; tick(); idle();
    irq_enter = 1; tick(); idle();
    total++;
    if (psr !== 16'h02E5 || in_irq !== 1'b1) begin bad++; $display("FAIL nested_enter: psr=%h in_irq=%b want 02E5/1", psr, in_irq); end
    irq_return = 1; flag_we = 1; flag_mask = 5'b11111; carry = 1; psr_we = 1; psr_wdata = 16'h0200; tick(); idle();
    total++;
    if (psr !== 16'h0040 || in_irq !== 1'b0) begin bad++; $display("FAIL return_priority: psr=%h in_irq=%b want 0040/0", psr, in_irq); end
  endtask

  task automatic test_sweep();
    int errs = 0;
    for (int f = 0; f < 32; f++)
      for (int c = 0; c < 16; c++) begin
        logic [4:0] fv;
        logic exp;
        fv = 5'(f);
        flag_we = 1; flag_mask = 5'b11111; cond_valid = 1; cond = 4'(c);
        {carry, low, flag, zero, negative} = fv;
        exp = cond_ref(4'(c), fv[4], fv[3], fv[2], fv[1], fv[0]);
        if (c == 14) exp = 1'b1;
        if (c == 15) exp = 1'b0;
        tick();
        total++;
        if (take_valid !== 1'b1 || take !== exp) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL sweep flags=%b cond=%0d: take=%b tv=%b want %b/1", fv, c, take, take_valid, exp);
        end
      end
    idle();
  endtask

  task automatic test_reset_irq();
    psr_we = 1; psr_wdata = 16'h02C1; irq_enter = 1; tick(); idle();
    reset = 1; cond_valid = 1; cond = 4'd14; tick(); idle();
    total++;
    if (psr !== 16'h0 || in_irq !== 1'b0 || take_valid !== 1'b0) begin
      bad++; $display("FAIL reset_in_irq: psr=%h in_irq=%b tv=%b want 0000/0/0", psr, in_irq, take_valid);
    end
    irq_return = 1; tick(); idle();
    total++;
    if (psr !== 16'h0 || in_irq !== 1'b0) begin bad++; $display("FAIL shadow_discard: psr=%h in_irq=%b want 0000/0", psr, in_irq); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 2000; i++) begin
      reset = $urandom_range(0, 63) == 0;
      {carry, low, flag, zero, negative} = 5'($urandom);
      flag_we = $urandom_range(0, 1) == 1;
      flag_mask = 5'($urandom);
      psr_we = $urandom_range(0, 5) == 0;
      psr_wdata = 16'($urandom);
      irq_enter = $urandom_range(0, 7) == 0;
      irq_return = $urandom_range(0, 7) == 0;
      cond_valid = $urandom_range(0, 1) == 1;
      cond = 4'($urandom);
      tick();
      total++;
      if (psr !== m_psr || in_irq !== m_irq || take_valid !== e_tv || (e_tv && take !== e_take)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL random[%0d]: psr=%h irq=%b tv=%b take=%b want %h/%b/%b/%b", i, psr, in_irq, take_valid, take, m_psr, m_irq, e_tv, e_take);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_flags();
    test_forward();
    test_irq();
    test_priority();
    test_sweep();
    test_reset_irq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
